// File: rtl/regs_wb_arb.sv
// Writeback arbiter for the integer register file: round-robin merge of NREQ writers
// onto the single registered rd port, plus a busy scoreboard for decode hazard stalls.
module regs_wb_arb #(
   parameter int NREQ = 3,
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid_i,
   input  logic [NREQ*AW-1:0]   req_addr_i,
   input  logic [NREQ*XLEN-1:0] req_data_i,
   output logic [NREQ-1:0]      req_ready_o,
   output logic                 rd_we_o,
   output logic [AW-1:0]        rd_addr_o,
   output logic [XLEN-1:0]      rd_data_o,
   input  logic                 iss_valid_i,
   input  logic [AW-1:0]        iss_rd_i,
   output logic                 iss_ready_o,
   input  logic [AW-1:0]        rs1_addr_i,
   input  logic [AW-1:0]        rs2_addr_i,
   output logic                 rs1_busy_o,
   output logic                 rs2_busy_o
);

   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int NREG = 1 << AW;

   logic [PW-1:0]   r_ptr;
   logic [NREG-1:0] r_busy;
   logic            r_rd_we;
   logic [AW-1:0]   r_rd_addr;
   logic [XLEN-1:0] r_rd_data;

   logic [NREQ-1:0] w_gnt;
   logic            w_any;
   logic [PW-1:0]   w_gidx;
   logic [AW-1:0]   w_gaddr;
   logic [XLEN-1:0] w_gdata;
   logic            w_iss_fire;
   logic [NREG-1:0] w_busy_nxt;

   // Rotation order k visits requester (ptr+k) mod NREQ; the first valid one wins.
   always_comb begin
      w_gnt   = '0;
      w_any   = 1'b0;
      w_gidx  = '0;
      w_gaddr = '0;
      w_gdata = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_any && req_valid_i[i] &&
                ((32'(r_ptr) + k) % 32'(NREQ)) == i) begin
               w_any    = 1'b1;
               w_gnt[i] = 1'b1;
               w_gidx   = PW'(i);
               w_gaddr  = req_addr_i[i*AW +: AW];
               w_gdata  = req_data_i[i*XLEN +: XLEN];
            end
         end
      end
   end

   // Held in reset, a grant would not be a real transfer, so ready is masked.
   assign req_ready_o = w_gnt & {NREQ{rst_n}};

   assign iss_ready_o = ~r_busy[iss_rd_i] | (iss_rd_i == '0);
   assign rs1_busy_o  = r_busy[rs1_addr_i] & (rs1_addr_i != '0);
   assign rs2_busy_o  = r_busy[rs2_addr_i] & (rs2_addr_i != '0);
   assign w_iss_fire  = iss_valid_i & iss_ready_o & (iss_rd_i != '0);

   // Clear applied before set so a same-cycle issue keeps ownership of the reg.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_any && (w_gaddr != '0))
         w_busy_nxt[w_gaddr] = 1'b0;
      if (w_iss_fire)
         w_busy_nxt[iss_rd_i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         r_busy    <= '0;
         r_rd_we   <= 1'b0;
         r_rd_addr <= '0;
         r_rd_data <= '0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_rd_we <= w_any && (w_gaddr != '0);
         if (w_any) begin
            r_rd_addr <= w_gaddr;
            r_rd_data <= w_gdata;
            if (w_gidx == PW'(NREQ - 1))
               r_ptr <= '0;
            else
               r_ptr <= w_gidx + PW'(1);
         end
      end
   end

   assign rd_we_o   = r_rd_we;
   assign rd_addr_o = r_rd_addr;
   assign rd_data_o = r_rd_data;

endmodule

// File: tb/tb_regs_wb_arb.sv
// Self-checking bench for regs_wb_arb: directed scenarios plus randomized traffic
// checked against a behavioural round-robin / scoreboard model.
module tb_regs_wb_arb;

   localparam int NREQ = 3;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]      req_valid_i;
   logic [AW-1:0]        aa [NREQ];
   logic [XLEN-1:0]      da [NREQ];
   logic [NREQ*AW-1:0]   req_addr_i;
   logic [NREQ*XLEN-1:0] req_data_i;
   logic [NREQ-1:0]      req_ready_o;
   logic                 rd_we_o;
   logic [AW-1:0]        rd_addr_o;
   logic [XLEN-1:0]      rd_data_o;
   logic                 iss_valid_i;
   logic [AW-1:0]        iss_rd_i;
   logic                 iss_ready_o;
   logic [AW-1:0]        rs1_addr_i, rs2_addr_i;
   logic                 rs1_busy_o, rs2_busy_o;

   assign req_addr_i = {aa[2], aa[1], aa[0]};
   assign req_data_i = {da[2], da[1], da[0]};

   regs_wb_arb #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .req_ready_o(req_ready_o),
      .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
      .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i), .iss_ready_o(iss_ready_o),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   int            m_ptr;
   bit            m_busy [32];
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_data;
   bit            m_x0;

   function automatic int model_grant();
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (req_valid_i[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] exp_ready();
      int g;
      g = model_grant();
      if (g < 0) return '0;
      return NREQ'(1 << g);
   endfunction

   function automatic logic exp_iss_ready();
      return (iss_rd_i == 0) || !m_busy[iss_rd_i];
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      m_we = 1'b0; m_addr = '0; m_data = '0; m_x0 = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied, then take the edge.
   task automatic cycle();
      int g;
      bit fire;
      g = model_grant();
      fire = iss_valid_i && exp_iss_ready();
      m_x0 = 1'b0;
      if (g >= 0) begin
         m_addr = aa[g];
         m_data = da[g];
         m_we   = (aa[g] != 0);
         m_x0   = (aa[g] == 0);
         if (aa[g] != 0) m_busy[aa[g]] = 1'b0;
         m_ptr = (g + 1) % NREQ;
      end else begin
         m_we = 1'b0;
      end
      if (fire && iss_rd_i != 0) m_busy[iss_rd_i] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid_i = '0;
      iss_valid_i = 1'b0;
      iss_rd_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
      for (int i = 0; i < NREQ; i++) begin aa[i] = '0; da[i] = '0; end
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      iss_valid_i = 1'b1; iss_rd_i = 5'd3;
      req_valid_i = 3'b001; aa[0] = 5'd4; da[0] = $urandom;
      cycle();
      iss_valid_i = 1'b0;
      rs1_addr_i = 5'd3;
      req_valid_i = 3'b111;
      aa[0] = 5'd11; aa[1] = 5'd12; aa[2] = 5'd13;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (rd_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", rd_we_o); end
      checks++; if (rd_addr_o !== '0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rd_addr_o); end
      checks++; if (rd_data_o !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", rd_data_o); end
      checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL reset_ready got %b exp 000", req_ready_o); end
      checks++; if (rs1_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", rs1_busy_o); end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #3;
      checks++; if (req_ready_o !== 3'b001) begin errors++; $display("FAIL reset_ptr got %b exp 001", req_ready_o); end
      req_valid_i = '0;
   endtask

   task automatic test_single();
      req_valid_i = 3'b001; aa[0] = 5'd5; da[0] = 32'hDEAD_BEEF;
      #3;
      checks++; if (req_ready_o !== 3'b001) begin errors++; $display("FAIL single_ready got %b exp 001", req_ready_o); end
      cycle();
      req_valid_i = '0;
      checks++; if (rd_we_o !== 1'b1) begin errors++; $display("FAIL single_we got %0b exp 1", rd_we_o); end
      checks++; if (rd_addr_o !== 5'd5) begin errors++; $display("FAIL single_addr got %0d exp 5", rd_addr_o); end
      checks++; if (rd_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", rd_data_o); end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] tab [6];
      tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      do_reset();
      req_valid_i = 3'b111;
      for (int i = 0; i < NREQ; i++) begin aa[i] = AW'(20 + i); da[i] = $urandom; end
      for (int c = 0; c < 6; c++) begin
         #3;
         checks++; if (req_ready_o !== tab[c]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", c, req_ready_o, tab[c]); end
         cycle();
         checks++; if (rd_addr_o !== AW'(20 + (c % 3)) || rd_data_o !== da[c % 3]) begin
            errors++; $display("FAIL rr_write%0d got %0d/%h exp %0d/%h", c, rd_addr_o, rd_data_o, 20 + (c % 3), da[c % 3]);
         end
      end
      req_valid_i = '0;
   endtask

   task automatic test_scoreboard();
      iss_valid_i = 1'b1; iss_rd_i = 5'd7; rs1_addr_i = 5'd7;
      #3;
      checks++; if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL sb_iss_free got %0b exp 1", iss_ready_o); end
      cycle();
      iss_valid_i = 1'b0;
      #3;
      checks++; if (rs1_busy_o !== 1'b1) begin errors++; $display("FAIL sb_raw got %0b exp 1", rs1_busy_o); end
      checks++; if (iss_ready_o !== 1'b0) begin errors++; $display("FAIL sb_waw got %0b exp 0", iss_ready_o); end
      req_valid_i = 3'b010; aa[1] = 5'd7; da[1] = $urandom;
      #1;
      checks++; if (req_ready_o !== 3'b010) begin errors++; $display("FAIL sb_lsu_ready got %b exp 010", req_ready_o); end
      checks++; if (rs1_busy_o !== 1'b1) begin errors++; $display("FAIL sb_nomask got %0b exp 1", rs1_busy_o); end
      cycle();
      req_valid_i = '0;
      #3;
      checks++; if (rs1_busy_o !== 1'b0) begin errors++; $display("FAIL sb_clear got %0b exp 0", rs1_busy_o); end
      checks++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd7) begin errors++; $display("FAIL sb_write got %0b/%0d exp 1/7", rd_we_o, rd_addr_o); end
   endtask

   task automatic test_collision();
      iss_valid_i = 1'b1; iss_rd_i = 5'd9;
      req_valid_i = 3'b100; aa[2] = 5'd9; da[2] = $urandom;
      #3;
      checks++; if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL col_iss got %0b exp 1", iss_ready_o); end
      checks++; if (req_ready_o !== 3'b100) begin errors++; $display("FAIL col_ready got %b exp 100", req_ready_o); end
      cycle();
      iss_valid_i = 1'b0; req_valid_i = '0; rs1_addr_i = 5'd9;
      #3;
      checks++; if (rs1_busy_o !== 1'b1) begin errors++; $display("FAIL col_setwins got %0b exp 1", rs1_busy_o); end
      checks++; if (iss_ready_o !== 1'b0) begin errors++; $display("FAIL col_waw got %0b exp 0", iss_ready_o); end
      checks++; if (rd_we_o !== 1'b1 || rd_addr_o !== 5'd9) begin errors++; $display("FAIL col_write got %0b/%0d exp 1/9", rd_we_o, rd_addr_o); end
      req_valid_i = 3'b010; aa[1] = 5'd9; da[1] = $urandom;
      cycle();
      req_valid_i = '0;
   endtask

   task automatic test_x0();
      iss_valid_i = 1'b1; iss_rd_i = 5'd12;
      cycle();
      iss_valid_i = 1'b0;
      req_valid_i = 3'b001; aa[0] = 5'd0; da[0] = $urandom;
      #3;
      checks++; if (req_ready_o !== 3'b001) begin errors++; $display("FAIL x0_ready got %b exp 001", req_ready_o); end
      cycle();
      req_valid_i = '0;
      checks++; if (rd_we_o !== 1'b0) begin errors++; $display("FAIL x0_we got %0b exp 0", rd_we_o); end
      req_valid_i = 3'b111;
      for (int i = 0; i < NREQ; i++) aa[i] = AW'(1 + i);
      #3;
      checks++; if (req_ready_o !== 3'b010) begin errors++; $display("FAIL x0_ptr got %b exp 010", req_ready_o); end
      req_valid_i = '0;
      iss_valid_i = 1'b1; iss_rd_i = 5'd0;
      #1;
      checks++; if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL x0_iss got %0b exp 1", iss_ready_o); end
      cycle();
      iss_valid_i = 1'b0; rs1_addr_i = 5'd0; rs2_addr_i = 5'd12;
      #3;
      checks++; if (rs1_busy_o !== 1'b0) begin errors++; $display("FAIL x0_busy got %0b exp 0", rs1_busy_o); end
      checks++; if (rs2_busy_o !== 1'b1) begin errors++; $display("FAIL x0_keep got %0b exp 1", rs2_busy_o); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         int g;
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid_i[i] && $urandom_range(0, 99) < 60) begin
               req_valid_i[i] = 1'b1;
               aa[i] = AW'($urandom_range(0, 7));
               da[i] = $urandom;
            end
         end
         iss_valid_i = ($urandom_range(0, 2) == 0);
         iss_rd_i    = AW'($urandom_range(0, 7));
         rs1_addr_i  = AW'($urandom_range(0, 7));
         rs2_addr_i  = AW'($urandom_range(0, 7));
         #3;
         checks++; if (req_ready_o !== exp_ready()) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, req_ready_o, exp_ready()); end
         checks++; if (iss_ready_o !== exp_iss_ready()) begin errors++; $display("FAIL rnd_iss c%0d got %0b exp %0b", c, iss_ready_o, exp_iss_ready()); end
         checks++; if (rs1_busy_o !== (rs1_addr_i != 0 && m_busy[rs1_addr_i])) begin
            errors++; $display("FAIL rnd_rs1 c%0d got %0b exp %0b", c, rs1_busy_o, rs1_addr_i != 0 && m_busy[rs1_addr_i]);
         end
         checks++; if (rs2_busy_o !== (rs2_addr_i != 0 && m_busy[rs2_addr_i])) begin
            errors++; $display("FAIL rnd_rs2 c%0d got %0b exp %0b", c, rs2_busy_o, rs2_addr_i != 0 && m_busy[rs2_addr_i]);
         end
         g = model_grant();
         cycle();
         if (g >= 0) req_valid_i[g] = 1'b0;
         checks++; if (rd_we_o !== m_we) begin errors++; $display("FAIL rnd_we c%0d got %0b exp %0b", c, rd_we_o, m_we); end
         if (!m_x0) begin
            checks++; if (rd_addr_o !== m_addr || rd_data_o !== m_data) begin
               errors++; $display("FAIL rnd_wr c%0d got %0d/%h exp %0d/%h", c, rd_addr_o, rd_data_o, m_addr, m_data);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_scoreboard();
      test_collision();
      test_x0();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
